// File: rtl/dense_backward_seq.sv
// Backward pass of a dense layer: sweeps weight/gradient memory word by word,
// accumulating dx = dy * W^T and writing G = x^T * dy (optionally added to old G).
module dense_backward_seq #(
    parameter int N          = 1,
    parameter int IN_DIM     = 2,
    parameter int OUT_DIM    = 8,
    parameter int DATA_W     = 16,
    parameter int FRAC       = 8,
    parameter int DATA_N     = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    input  logic [2:0]                     mode,
    input  logic [N*IN_DIM*DATA_W-1:0]     d_forward,
    input  logic [N*OUT_DIM*DATA_W-1:0]    d_backward,
    output logic                           valid,
    output logic                           busy,
    output logic [N*IN_DIM*DATA_W-1:0]     q,
    output logic [ADDR_WIDTH-1:0]          raddr_w,
    output logic [ADDR_WIDTH-1:0]          raddr_grad,
    input  logic [DATA_N*DATA_W-1:0]       rdata_w,
    input  logic [DATA_N*DATA_W-1:0]       rdata_grad,
    output logic                           we,
    output logic [ADDR_WIDTH-1:0]          waddr,
    output logic [DATA_N*DATA_W-1:0]       wdata
);

    localparam int WORDS = IN_DIM * OUT_DIM / DATA_N;
    localparam int WPR   = OUT_DIM / DATA_N;
    localparam int ROW_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int COL_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int ACC_W = 2 * DATA_W + $clog2(OUT_DIM) + $clog2(N) + 2;

    localparam logic [ADDR_WIDTH-1:0]   LAST_K   = ADDR_WIDTH'(WORDS - 1);
    localparam logic [COL_W-1:0]        LAST_COL = COL_W'(WPR - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    if ((OUT_DIM % DATA_N) != 0 || longint'(WORDS) > (64'sd1 <<< ADDR_WIDTH)) begin : g_cfg_check
        $error("dense_backward_seq: OUT_DIM must be a multiple of DATA_N and WORDS must fit ADDR_WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t                          r_state, w_state;
    logic [N*IN_DIM*DATA_W-1:0]      r_x;
    logic [N*OUT_DIM*DATA_W-1:0]     r_dy;
    logic [2:0]                      r_mode;
    logic [ADDR_WIDTH-1:0]           r_raddr;
    logic [ROW_W-1:0]                r_row;
    logic [COL_W-1:0]                r_col;
    logic                            r_vld_p1;
    logic [ADDR_WIDTH-1:0]           r_k_p1;
    logic [ROW_W-1:0]                r_row_p1;
    logic [COL_W-1:0]                r_col_p1;
    logic                            r_drain;
    logic signed [ACC_W-1:0]         r_acc [N][IN_DIM];
    logic [N*IN_DIM*DATA_W-1:0]      r_q;
    logic                            r_we;
    logic [ADDR_WIDTH-1:0]           r_waddr;
    logic [DATA_N*DATA_W-1:0]        r_wdata;
    logic signed [ACC_W-1:0]         w_dx_sum [N];
    logic [DATA_N*DATA_W-1:0]        w_gdata;
    logic                            w_start;

    function automatic logic signed [DATA_W-1:0] rnd_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> FRAC;
        if (s > SAT_MAX)      rnd_sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (s < SAT_MIN) rnd_sat = {1'b1, {(DATA_W-1){1'b0}}};
        else                  rnd_sat = s[DATA_W-1:0];
    endfunction

    assign w_start = (r_state == S_IDLE) && run;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state;
    end

    always_comb begin
        w_state = r_state;
        case (r_state)
            S_IDLE:  if (run) w_state = (mode[1:0] == 2'b00) ? S_DONE : S_SWEEP;
            S_SWEEP: if (!run) w_state = S_IDLE;
                     else if (r_raddr == LAST_K) w_state = S_DRAIN;
            S_DRAIN: if (!run) w_state = S_IDLE;
                     else if (r_drain) w_state = S_DONE;
            S_DONE:  if (!run) w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    // p1: memory data for word r_k_p1 is on rdata_*; form lane products
    always_comb begin
        logic signed [ACC_W-1:0] w_g;
        int o;
        for (int n = 0; n < N; n++) w_dx_sum[n] = '0;
        w_gdata = '0;
        for (int j = 0; j < DATA_N; j++) begin
            o   = int'(r_col_p1) * DATA_N + j;
            w_g = r_mode[2] ? (ACC_W'($signed(rdata_grad[j*DATA_W +: DATA_W])) <<< FRAC) : '0;
            for (int n = 0; n < N; n++) begin
                w_dx_sum[n] = w_dx_sum[n]
                    + ACC_W'($signed(rdata_w[j*DATA_W +: DATA_W]))
                    * ACC_W'($signed(r_dy[(n*OUT_DIM + o)*DATA_W +: DATA_W]));
                w_g = w_g
                    + ACC_W'($signed(r_x[(n*IN_DIM + int'(r_row_p1))*DATA_W +: DATA_W]))
                    * ACC_W'($signed(r_dy[(n*OUT_DIM + o)*DATA_W +: DATA_W]));
            end
            w_gdata[j*DATA_W +: DATA_W] = rnd_sat(w_g);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_dy     <= '0;
            r_mode   <= '0;
            r_raddr  <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_vld_p1 <= 1'b0;
            r_k_p1   <= '0;
            r_row_p1 <= '0;
            r_col_p1 <= '0;
            r_drain  <= 1'b0;
            r_q      <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            for (int n = 0; n < N; n++)
                for (int i = 0; i < IN_DIM; i++) r_acc[n][i] <= '0;
        end else begin
            // p0: address issue and captured operands
            if (w_start) begin
                r_x     <= d_forward;
                r_dy    <= d_backward;
                r_mode  <= mode;
                r_raddr <= '0;
                r_row   <= '0;
                r_col   <= '0;
                for (int n = 0; n < N; n++)
                    for (int i = 0; i < IN_DIM; i++) r_acc[n][i] <= '0;
            end else if (r_state == S_SWEEP && run && r_raddr != LAST_K) begin
                r_raddr <= r_raddr + 1'b1;
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            r_vld_p1 <= (r_state == S_SWEEP) && run;
            r_k_p1   <= r_raddr;
            r_row_p1 <= r_row;
            r_col_p1 <= r_col;

            // p2: gradient write and dx accumulation; run low drops the word
            r_we <= r_vld_p1 && run && r_mode[1];
            if (r_vld_p1 && run && r_mode[1]) begin
                r_waddr <= r_k_p1;
                r_wdata <= w_gdata;
            end
            if (r_vld_p1 && run && r_mode[0]) begin
                for (int n = 0; n < N; n++)
                    r_acc[n][r_row_p1] <= r_acc[n][r_row_p1] + w_dx_sum[n];
            end

            r_drain <= (r_state == S_DRAIN) && run;
            if (r_state == S_DRAIN && run && r_drain && r_mode[0]) begin
                for (int n = 0; n < N; n++)
                    for (int i = 0; i < IN_DIM; i++)
                        r_q[(n*IN_DIM + i)*DATA_W +: DATA_W] <= rnd_sat(r_acc[n][i]);
            end
        end
    end

    assign busy       = (r_state == S_SWEEP) || (r_state == S_DRAIN);
    assign valid      = (r_state == S_DONE);
    assign q          = r_q;
    assign raddr_w    = r_raddr;
    assign raddr_grad = r_raddr;
    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;

endmodule
